// File: rtl/bus_source_arbiter.sv
// Bus-source arbiter: round-robin (or fixed priority with BUS_ARB_FIXED_PRIO_EN) one-hot grant plus encoded select.
// Latency one edge from request in IDLE to grant; locked transfers are bounded by LOCK_MAX, releases insert TURNAROUND idle cycles.
module bus_source_arbiter #(
  parameter int NUM_REQ    = 24,
  parameter int SEL_W      = 5,
  parameter int LOCK_MAX   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   bus_sel,
  output logic               busy,
  output logic               lock_timeout
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic                 to_q, to_d;
  logic [PTR_W-1:0]     idx_q, idx_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [TURN_W-1:0]    turn_q, turn_d;
  logic [PTR_W-1:0]     base;

`ifdef BUS_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  assign base = rr_ptr_q;
`endif

  // Rotate requests so the scan start sits at bit 0, then take the lowest set bit.
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [PTR_W-1:0]     off;
  logic [PTR_W:0]       sum;
  logic [PTR_W-1:0]     win;
  logic                 found;

  always_comb begin
    dbl   = {req, req} >> base;
    rot   = dbl[NUM_REQ-1:0];
    off   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = PTR_W'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
    win = sum[PTR_W-1:0];
  end

  logic release_now;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    turn_d      = turn_q;
    to_d        = 1'b0;
    release_now = 1'b0;
`ifndef BUS_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          sel_d      = SEL_W'(win) + SEL_W'(1);
          idx_d      = win;
          hold_d     = '0;
          // With LOCK_MAX of 1 the very first grant cycle is already the forced-release one.
          to_d       = (LOCK_MAX == 1) && lock[win];
          state_d    = S_GRANT;
`ifndef BUS_ARB_FIXED_PRIO_EN
          rr_ptr_d   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
`endif
        end
      end
      S_GRANT: begin
        if (lock[idx_q] && req[idx_q] && (hold_q < HOLD_LAST)) begin
          hold_d = hold_q + HOLD_W'(1);
          to_d   = (hold_d == HOLD_LAST);
        end else begin
          release_now = 1'b1;
        end
      end
      S_TURN: begin
        if (turn_q == '0) state_d = S_IDLE;
        else              turn_d  = turn_q - TURN_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (release_now) begin
      gnt_d = '0;
      sel_d = '0;
      if (TURNAROUND > 0) begin
        state_d = S_TURN;
        turn_d  = TURN_W'(TURNAROUND - 1);
      end else begin
        state_d = S_IDLE;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
      idx_q    <= '0;
      hold_q   <= '0;
      turn_q   <= '0;
`ifndef BUS_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      to_q     <= to_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
`ifndef BUS_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign gnt          = gnt_q;
  assign bus_sel      = sel_q;
  assign busy         = busy_q;
  assign lock_timeout = to_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed bench for bus_source_arbiter (default round-robin build, default parameters).
module tb_bus_source_arbiter;

  logic        clock = 1'b0;
  logic        clear;
  logic [23:0] req;
  logic [23:0] lock;
  logic [23:0] gnt;
  logic [4:0]  bus_sel;
  logic        busy;
  logic        lock_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  bus_source_arbiter dut (
    .clock        (clock),
    .clear        (clear),
    .req          (req),
    .lock         (lock),
    .gnt          (gnt),
    .bus_sel      (bus_sel),
    .busy         (busy),
    .lock_timeout (lock_timeout)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [23:0] eg, input logic [4:0] es,
                           input logic eb, input logic et);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".bus_sel"}, 32'(bus_sel), 32'(es));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".lock_timeout"}, 32'(lock_timeout), 32'(et));
  endtask

  function automatic logic [23:0] bit_of(input int n);
    logic [23:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  initial begin
    int exp_w [4];
    exp_w = '{5, 0, 5, 0};

    // Reset held with every requester active
    clear = 1'b0;
    req   = 24'hFFFFFF;
    lock  = 24'h0;
    step();
    check_out("reset1", 24'h0, 5'd0, 1'b0, 1'b0);
    step();
    check_out("reset2", 24'h0, 5'd0, 1'b0, 1'b0);
    clear = 1'b1;
    req   = 24'h0;
    step();
    check_out("idle", 24'h0, 5'd0, 1'b0, 1'b0);

    // Single transfer to R2
    req = bit_of(2);
    step();
    check_out("single.gnt", 24'h000004, 5'd3, 1'b1, 1'b0);
    req = 24'h0;
    step();
    check_out("single.turn", 24'h0, 5'd0, 1'b1, 1'b0);
    step();
    check_out("single.idle", 24'h0, 5'd0, 1'b0, 1'b0);

    // Fairness: rr_ptr is 3 after granting R2, so R5 goes first
    req = bit_of(0) | bit_of(5);
    for (int k = 0; k < 4; k++) begin
      step();
      check_out($sformatf("fair%0d.gnt", k), bit_of(exp_w[k]), 5'(exp_w[k] + 1), 1'b1, 1'b0);
      step();
      check_out($sformatf("fair%0d.turn", k), 24'h0, 5'd0, 1'b1, 1'b0);
      step();
      check_out($sformatf("fair%0d.idle", k), 24'h0, 5'd0, 1'b0, 1'b0);
    end

    // Wrap: grant C, then R1 wins from rr_ptr 0
    req = bit_of(23);
    step();
    check_out("wrap.c", 24'h800000, 5'b11000, 1'b1, 1'b0);
    req = bit_of(23) | bit_of(1);
    step();
    check_out("wrap.turn", 24'h0, 5'd0, 1'b1, 1'b0);
    step();
    check_out("wrap.idle", 24'h0, 5'd0, 1'b0, 1'b0);
    step();
    check_out("wrap.r1", 24'h000002, 5'b00010, 1'b1, 1'b0);
    req = 24'h0;
    step();
    step();
    check_out("wrap.done", 24'h0, 5'd0, 1'b0, 1'b0);

    // Lock bound: PC held for exactly 8 cycles, timeout in the 8th
    req  = bit_of(20);
    lock = bit_of(20);
    for (int c = 1; c <= 8; c++) begin
      step();
      check_out($sformatf("lock.c%0d", c), 24'h100000, 5'd21, 1'b1, (c == 8));
    end
    step();
    check_out("lock.turn", 24'h0, 5'd0, 1'b1, 1'b0);
    step();
    check_out("lock.idle", 24'h0, 5'd0, 1'b0, 1'b0);
    step();
    check_out("lock.regrant", 24'h100000, 5'd21, 1'b1, 1'b0);
    step();
    check_out("lock2.c2", 24'h100000, 5'd21, 1'b1, 1'b0);
    step();
    check_out("lock2.c3", 24'h100000, 5'd21, 1'b1, 1'b0);
    lock = 24'h0;
    req  = 24'h0;
    step();
    check_out("lock2.release", 24'h0, 5'd0, 1'b1, 1'b0);
    step();
    check_out("lock2.idle", 24'h0, 5'd0, 1'b0, 1'b0);

    // Reset during cycle 4 of a locked MDR grant
    req  = bit_of(21);
    lock = bit_of(21);
    for (int c = 1; c <= 4; c++) begin
      step();
      check_out($sformatf("mdr.c%0d", c), 24'h200000, 5'd22, 1'b1, 1'b0);
    end
    clear = 1'b0;
    step();
    check_out("mdr.reset", 24'h0, 5'd0, 1'b0, 1'b0);
    clear = 1'b1;
    req   = bit_of(21) | bit_of(0);
    step();
    check_out("mdr.after", 24'h000001, 5'd1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
